// File: rtl/instr_stage_sequencer_if.sv
// Sequencer-to-datapath/memory bundle for the UrCPU instruction stage sequencer.
// master = sequencer side, slave = memory/ControlUnit side.
interface instr_stage_sequencer_if #(
    parameter int unsigned DATA_W = 20,
    parameter int unsigned CNT_W  = 16
) ();
    logic              start;
    logic [DATA_W-1:0] instr_in;
    logic              mem_ready;
    logic              mem_req;
    logic              mem_we;
    logic              ir_load;
    logic              pc_inc;
    logic              wb_en;
    logic [1:0]        Instr_Stage;
    logic [3:0]        opCode;
    logic              stage_valid;
    logic              halted;
    logic              error;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  instr_count;

    modport master (
        input  start, instr_in, mem_ready,
        output mem_req, mem_we, ir_load, pc_inc, wb_en, Instr_Stage, opCode,
               stage_valid, halted, error, cycle_count, instr_count
    );

    modport slave (
        output start, instr_in, mem_ready,
        input  mem_req, mem_we, ir_load, pc_inc, wb_en, Instr_Stage, opCode,
               stage_valid, halted, error, cycle_count, instr_count
    );
endinterface

// File: rtl/instr_stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM sequencer for the 20-bit UrCPU with
// memory-timeout halt and saturating cycle / retired-instruction counters.
module instr_stage_sequencer #(
    parameter int unsigned DATA_W      = 20,
    parameter logic [3:0]  OP_LOAD     = 4'b1000,
    parameter logic [3:0]  OP_STORE    = 4'b1001,
    parameter logic [3:0]  OP_HALT     = 4'b1111,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    instr_stage_sequencer_if.master bus
);
    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         opcode_q, opcode_d;
    logic               error_q, error_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   icnt_q, icnt_d;

    logic mem_req, stage_valid, mem_wait, timeout, retire;
    logic ir_load, pc_inc, wb_en;

    // Moore decode from the state register
    assign mem_req     = (state_q == S_FETCH) || (state_q == S_MEM);
    assign stage_valid = (state_q != S_IDLE) && (state_q != S_HALT);
    assign mem_wait    = mem_req && !bus.mem_ready;
    assign timeout     = mem_wait && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opcode_q <= 4'd0;
            error_q  <= 1'b0;
            wait_q   <= '0;
            cyc_q    <= '0;
            icnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            error_q  <= error_d;
            wait_q   <= wait_d;
            cyc_q    <= cyc_d;
            icnt_q   <= icnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        error_d  = error_q;
        wait_d   = mem_wait ? wait_q + WAIT_W'(1) : wait_q;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        wb_en    = 1'b0;
        retire   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (bus.mem_ready) begin
                    ir_load  = 1'b1;
                    pc_inc   = 1'b1;
                    opcode_d = bus.instr_in[DATA_W-1 -: 4];
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end
            end
            S_DECODE: begin
                state_d = (opcode_q == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                wait_d = '0;
                if ((opcode_q == OP_LOAD) || (opcode_q == OP_STORE)) begin
                    state_d = S_MEM;
                end else begin
                    wb_en   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    wb_en   = (opcode_q == OP_LOAD);
                    retire  = 1'b1;
                    wait_d  = '0;
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_HALT;
                    error_d = 1'b1;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        // Saturating performance counters
        cyc_d  = (stage_valid && (cyc_q != '1)) ? cyc_q + CNT_W'(1) : cyc_q;
        icnt_d = (retire && (icnt_q != '1)) ? icnt_q + CNT_W'(1) : icnt_q;
    end

    always_comb begin
        unique case (state_q)
            S_FETCH:  bus.Instr_Stage = 2'b00;
            S_DECODE: bus.Instr_Stage = 2'b01;
            S_EXEC:   bus.Instr_Stage = 2'b10;
            S_MEM:    bus.Instr_Stage = 2'b11;
            default:  bus.Instr_Stage = 2'b00;
        endcase
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = (state_q == S_MEM) && (opcode_q == OP_STORE);
    assign bus.ir_load     = ir_load;
    assign bus.pc_inc      = pc_inc;
    assign bus.wb_en       = wb_en;
    assign bus.opCode      = opcode_q;
    assign bus.stage_valid = stage_valid;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.error       = error_q;
    assign bus.cycle_count = cyc_q;
    assign bus.instr_count = icnt_q;
endmodule

// File: tb/tb_instr_stage_sequencer.sv
// Directed-vector scoreboard bench for instr_stage_sequencer (MEM_TIMEOUT=4).
module tb_instr_stage_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_stage_sequencer_if #(.DATA_W(20), .CNT_W(16)) bus ();

    instr_stage_sequencer #(
        .DATA_W(20), .OP_LOAD(4'b1000), .OP_STORE(4'b1001), .OP_HALT(4'b1111),
        .MEM_TIMEOUT(4), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // flags = {stage_valid, mem_req, mem_we, ir_load, pc_inc, wb_en, halted, error}
    typedef struct {
        string       name;
        logic [1:0]  stage;
        logic [7:0]  flags;
        logic [3:0]  op;
        logic [15:0] cyc;
        logic [15:0] icnt;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    localparam logic [19:0] I_ALU   = 20'h2_0000;
    localparam logic [19:0] I_LOAD  = 20'h8_1234;
    localparam logic [19:0] I_STORE = 20'h9_0001;
    localparam logic [19:0] I_HALT  = 20'hF_0000;

    localparam logic [7:0] F_IDLE  = 8'b0000_0000;
    localparam logic [7:0] F_FRDY  = 8'b1101_1000;
    localparam logic [7:0] F_WAIT  = 8'b1100_0000;
    localparam logic [7:0] F_PLAIN = 8'b1000_0000;
    localparam logic [7:0] F_EXWB  = 8'b1000_0100;
    localparam logic [7:0] F_LDONE = 8'b1100_0100;
    localparam logic [7:0] F_STORE = 8'b1110_0000;
    localparam logic [7:0] F_HALT  = 8'b0000_0010;
    localparam logic [7:0] F_TOUT  = 8'b0000_0011;

    // Drive one cycle of inputs and queue the outputs expected during that cycle
    task automatic vec(input string nm, input logic r, input logic st, input logic [19:0] ins,
                       input logic rdy, input logic [1:0] stg, input logic [7:0] fl,
                       input logic [3:0] op, input int cyc, input int icnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.start     = st;
        bus.instr_in  = ins;
        bus.mem_ready = rdy;
        e.name  = nm;
        e.stage = stg;
        e.flags = fl;
        e.op    = op;
        e.cyc   = 16'(cyc);
        e.icnt  = 16'(icnt);
        q.push_back(e);
    endtask

    // Monitor: compares every presented cycle against the queued expectation
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {bus.stage_valid, bus.mem_req, bus.mem_we, bus.ir_load,
                       bus.pc_inc, bus.wb_en, bus.halted, bus.error};
                n_vec++;
                if (bus.Instr_Stage !== e.stage || act !== e.flags || bus.opCode !== e.op ||
                    bus.cycle_count !== e.cyc || bus.instr_count !== e.icnt) begin
                    n_fail++;
                    $display("FAIL %s: got stage=%b flags=%b op=%h cyc=%0d icnt=%0d, want stage=%b flags=%b op=%h cyc=%0d icnt=%0d",
                             e.name, bus.Instr_Stage, act, bus.opCode, bus.cycle_count,
                             bus.instr_count, e.stage, e.flags, e.op, e.cyc, e.icnt);
                end
            end
        end
    end

    initial begin
        bus.start     = 1'b0;
        bus.instr_in  = '0;
        bus.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, mem_ready ignored in IDLE, ALU op
        vec("idle_rst",   0, 0, I_ALU,   1, 2'b00, F_IDLE,  4'h0,  0, 0);
        vec("idle_start", 0, 1, I_ALU,   1, 2'b00, F_IDLE,  4'h0,  0, 0);
        vec("alu_fetch",  0, 0, I_ALU,   1, 2'b00, F_FRDY,  4'h0,  0, 0);
        vec("alu_dec",    0, 1, I_ALU,   1, 2'b01, F_PLAIN, 4'h2,  1, 0);
        vec("alu_exec",   0, 0, I_ALU,   1, 2'b10, F_EXWB,  4'h2,  2, 0);
        // LOAD with two MEM wait states
        vec("ld_fetch",   0, 0, I_LOAD,  1, 2'b00, F_FRDY,  4'h2,  3, 1);
        vec("ld_dec",     0, 0, I_LOAD,  1, 2'b01, F_PLAIN, 4'h8,  4, 1);
        vec("ld_exec",    0, 0, I_LOAD,  0, 2'b10, F_PLAIN, 4'h8,  5, 1);
        vec("ld_mem1",    0, 0, I_LOAD,  0, 2'b11, F_WAIT,  4'h8,  6, 1);
        vec("ld_mem2",    0, 0, I_LOAD,  0, 2'b11, F_WAIT,  4'h8,  7, 1);
        vec("ld_mem3",    0, 0, I_LOAD,  1, 2'b11, F_LDONE, 4'h8,  8, 1);
        // STORE
        vec("st_fetch",   0, 0, I_STORE, 1, 2'b00, F_FRDY,  4'h8,  9, 2);
        vec("st_dec",     0, 0, I_STORE, 1, 2'b01, F_PLAIN, 4'h9, 10, 2);
        vec("st_exec",    0, 0, I_STORE, 1, 2'b10, F_PLAIN, 4'h9, 11, 2);
        vec("st_mem",     0, 0, I_STORE, 1, 2'b11, F_STORE, 4'h9, 12, 2);
        // HALT after one fetch wait state; start ignored while halted
        vec("h_fwait",    0, 0, I_HALT,  0, 2'b00, F_WAIT,  4'h9, 13, 3);
        vec("h_fetch",    0, 0, I_HALT,  1, 2'b00, F_FRDY,  4'h9, 14, 3);
        vec("h_dec",      0, 0, I_HALT,  1, 2'b01, F_PLAIN, 4'hF, 15, 3);
        vec("h_halt1",    0, 1, I_ALU,   1, 2'b00, F_HALT,  4'hF, 16, 3);
        vec("h_halt2",    0, 1, I_ALU,   1, 2'b00, F_HALT,  4'hF, 16, 3);
        vec("h_rst",      1, 0, I_ALU,   1, 2'b00, F_HALT,  4'hF, 16, 3);
        vec("h_idle",     0, 0, I_ALU,   0, 2'b00, F_IDLE,  4'h0,  0, 0);
        // Fetch timeout after 4 unanswered cycles
        vec("to_start",   0, 1, I_ALU,   0, 2'b00, F_IDLE,  4'h0,  0, 0);
        vec("to_w1",      0, 0, I_ALU,   0, 2'b00, F_WAIT,  4'h0,  0, 0);
        vec("to_w2",      0, 0, I_ALU,   0, 2'b00, F_WAIT,  4'h0,  1, 0);
        vec("to_w3",      0, 0, I_ALU,   0, 2'b00, F_WAIT,  4'h0,  2, 0);
        vec("to_w4",      0, 0, I_ALU,   0, 2'b00, F_WAIT,  4'h0,  3, 0);
        vec("to_halt",    0, 1, I_ALU,   1, 2'b00, F_TOUT,  4'h0,  4, 0);
        vec("to_halt2",   0, 0, I_ALU,   1, 2'b00, F_TOUT,  4'h0,  4, 0);
        vec("to_rst",     1, 0, I_ALU,   0, 2'b00, F_TOUT,  4'h0,  4, 0);
        vec("to_idle",    0, 0, I_ALU,   0, 2'b00, F_IDLE,  4'h0,  0, 0);
        // Reset in the middle of a LOAD wait, then clean restart
        vec("rm_start",   0, 1, I_LOAD,  1, 2'b00, F_IDLE,  4'h0,  0, 0);
        vec("rm_fetch",   0, 0, I_LOAD,  1, 2'b00, F_FRDY,  4'h0,  0, 0);
        vec("rm_dec",     0, 0, I_LOAD,  0, 2'b01, F_PLAIN, 4'h8,  1, 0);
        vec("rm_exec",    0, 0, I_LOAD,  0, 2'b10, F_PLAIN, 4'h8,  2, 0);
        vec("rm_mem1",    0, 0, I_LOAD,  0, 2'b11, F_WAIT,  4'h8,  3, 0);
        vec("rm_mem_rst", 1, 0, I_LOAD,  0, 2'b11, F_WAIT,  4'h8,  4, 0);
        vec("rm_idle",    0, 0, I_ALU,   1, 2'b00, F_IDLE,  4'h0,  0, 0);
        vec("rs_start",   0, 1, I_ALU,   1, 2'b00, F_IDLE,  4'h0,  0, 0);
        vec("rs_fetch",   0, 0, I_ALU,   1, 2'b00, F_FRDY,  4'h0,  0, 0);
        vec("rs_dec",     0, 0, I_ALU,   1, 2'b01, F_PLAIN, 4'h2,  1, 0);
        vec("rs_exec",    0, 0, I_ALU,   1, 2'b10, F_EXWB,  4'h2,  2, 0);
        vec("rs_fetch2",  0, 0, I_ALU,   0, 2'b00, F_WAIT,  4'h2,  3, 1);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected vectors never compared, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
